asa_req_sched: RTL and testbench

Round-robin scheduler sharing one ASA accelerator core among `N_REQ` NoC decoder ports in a tile. Each port's decoded request is buffered in a one-entry slot. The scheduler issues one request at a time to the core and waits for its response. It then returns the response paired with that port's NoC response header, and runs a watchdog on outstanding requests.

---
 rtl/asa_pkg.sv | 35 +++
 rtl/asa_req_sched_if.sv | 61 ++++++
 rtl/asa_req_slot.sv | 59 +++++
 rtl/asa_req_sched.sv | 181 ++++++++++++++++++
 tb/tb_asa_req_sched.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/asa_pkg.sv
// Shared types for the ASA request scheduler.
//   ASAReqMsg     : request payload presented to the ASA core
//   asa_inst_e    : ASA instruction opcodes
//   sched_state_e : scheduler FSM states
//   QPUT          : NoC message type carrying ASA requests
package asa_pkg;

  localparam int unsigned HDR_W  = 32;
  localparam int unsigned KEY_W  = 32;
  localparam int unsigned DATA_W = 64;

  localparam logic [7:0] QPUT = 8'h05;

  typedef enum logic [2:0] {
    ASA_NOP = 3'd0,
    ASA_PUT = 3'd1,
    ASA_GET = 3'd2,
    ASA_DEL = 3'd3,
    ASA_INC = 3'd4
  } asa_inst_e;

  typedef struct packed {
    asa_inst_e          inst;
    logic [KEY_W-1:0]   key;
    logic [DATA_W-1:0]  data;
  } ASAReqMsg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/asa_req_sched_if.sv
// Bus bundle of the ASA request scheduler.
//   decoder side : hdr_vld/hdr, req_val/req_msg in; req_rdy/req_ovf out
//   core side    : asa_req_* request handshake, asa_resp_* response handshake
//   encoder side : out_val/out_rdy with out_hdr/out_data/out_src
//   status       : timeout_err, err_sticky, busy
// slave is the scheduler view, master the surrounding tile view.
interface asa_req_sched_if #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) ();
  import asa_pkg::*;

  logic [N_REQ-1:0]             hdr_vld;
  logic [N_REQ-1:0][HDR_W-1:0]  hdr;
  logic [N_REQ-1:0]             req_val;
  ASAReqMsg [N_REQ-1:0]         req_msg;
  logic [N_REQ-1:0]             req_rdy;
  logic [N_REQ-1:0]             req_ovf;

  logic                         asa_req_val;
  logic                         asa_req_rdy;
  ASAReqMsg                     asa_req_msg;
  logic                         asa_resp_val;
  logic                         asa_resp_rdy;
  logic [DATA_W-1:0]            asa_resp_data;

  logic                         out_val;
  logic                         out_rdy;
  logic [HDR_W-1:0]             out_hdr;
  logic [DATA_W-1:0]            out_data;
  logic [IDX_W-1:0]             out_src;

  logic                         timeout_err;
  logic                         err_sticky;
  logic                         busy;

  modport slave (
    input  hdr_vld, hdr, req_val, req_msg,
    output req_rdy, req_ovf,
    output asa_req_val, asa_req_msg,
    input  asa_req_rdy,
    input  asa_resp_val, asa_resp_data,
    output asa_resp_rdy,
    output out_val, out_hdr, out_data, out_src,
    input  out_rdy,
    output timeout_err, err_sticky, busy
  );

  modport master (
    output hdr_vld, hdr, req_val, req_msg,
    input  req_rdy, req_ovf,
    input  asa_req_val, asa_req_msg,
    output asa_req_rdy,
    output asa_resp_val, asa_resp_data,
    input  asa_resp_rdy,
    input  out_val, out_hdr, out_data, out_src,
    output out_rdy,
    input  timeout_err, err_sticky, busy
  );

endinterface

// File: rtl/asa_req_slot.sv
// One requester port: response-header latch, one-entry request slot and
// overflow detection.
//   hdr_vld/hdr      : header strobe, latched unconditionally
//   req_val/req_msg  : single-cycle request strobe (no backpressure)
//   issue            : scheduler completed the core handshake for this slot
//   pend_c           : slot holds a request
//   rdy              : slot empty (registered)
//   ovf              : registered pulse for a dropped request
//   drop_c           : same-cycle drop indication for the sticky error
//   slot_msg/slot_hdr: buffered request and the header captured with it
module asa_req_slot
  import asa_pkg::*;
(
  input  logic              clk_ctrl,
  input  logic              clk_ctrl_rst_low,
  input  logic              hdr_vld,
  input  logic [HDR_W-1:0]  hdr,
  input  logic              req_val,
  input  ASAReqMsg          req_msg,
  input  logic              issue,
  output logic              pend_c,
  output logic              rdy,
  output logic              ovf,
  output logic              drop_c,
  output ASAReqMsg          slot_msg,
  output logic [HDR_W-1:0]  slot_hdr
);

  logic [HDR_W-1:0] hdr_lat;
  logic             free_c;
  logic             accept_c;

  // A slot being issued this cycle is free for a new request.
  assign free_c   = rdy | issue;
  assign accept_c = req_val & free_c;
  assign drop_c   = req_val & ~free_c;
  assign pend_c   = ~rdy;

  // Header latch, slot payload, occupancy and overflow pulse.
  always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
    if (!clk_ctrl_rst_low) begin
      hdr_lat  <= '0;
      slot_msg <= '0;
      slot_hdr <= '0;
      rdy      <= 1'b1;
      ovf      <= 1'b0;
    end else begin
      if (hdr_vld) hdr_lat <= hdr;
      if (accept_c) begin
        slot_msg <= req_msg;
        slot_hdr <= hdr_lat;
      end
      if (accept_c)   rdy <= 1'b0;
      else if (issue) rdy <= 1'b1;
      ovf <= drop_c;
    end
  end

endmodule

// File: rtl/asa_req_sched.sv
// Round-robin scheduler sharing one ASA core among N_REQ decoder ports.
// Issues one buffered request at a time, waits for the core response and
// returns it with the originating port's response header. A watchdog
// abandons a request whose response does not arrive within TIMEOUT cycles
// (TIMEOUT = 0 disables it).
//   clk_ctrl, clk_ctrl_rst_low : clock, async active-low reset
//   bus (slave)                : decoder, core, encoder and status signals
module asa_req_sched
  import asa_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned IDX_W   = $clog2(N_REQ),
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic           clk_ctrl,
  input  logic           clk_ctrl_rst_low,
  asa_req_sched_if.slave bus
);

  localparam int unsigned WD_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  // First pending port strictly after ptr, wrapping modulo N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] sel;
    logic             found;
    int unsigned      j;
    sel   = ptr;
    found = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      j = 32'(ptr) + off;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[IDX_W'(j)]) begin
        sel   = IDX_W'(j);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  sched_state_e      state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [WD_W-1:0]   wd_cnt;
  logic [HDR_W-1:0]  cur_hdr;

  logic [N_REQ-1:0]  pend, rdy, ovf, drop, issue_c;
  ASAReqMsg          slot_msg [N_REQ];
  logic [HDR_W-1:0]  slot_hdr [N_REQ];

  logic              issue_hs, take_resp, expire;

  logic              asa_req_val_q, asa_resp_rdy_q, out_val_q;
  ASAReqMsg          asa_req_msg_q;
  logic [HDR_W-1:0]  out_hdr_q;
  logic [DATA_W-1:0] out_data_q;
  logic [IDX_W-1:0]  out_src_q;
  logic              timeout_err_q, err_sticky_q, busy_q;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    asa_req_slot u_slot (
      .clk_ctrl         (clk_ctrl),
      .clk_ctrl_rst_low (clk_ctrl_rst_low),
      .hdr_vld          (bus.hdr_vld[g]),
      .hdr              (bus.hdr[g]),
      .req_val          (bus.req_val[g]),
      .req_msg          (bus.req_msg[g]),
      .issue            (issue_c[g]),
      .pend_c           (pend[g]),
      .rdy              (rdy[g]),
      .ovf              (ovf[g]),
      .drop_c           (drop[g]),
      .slot_msg         (slot_msg[g]),
      .slot_hdr         (slot_hdr[g])
    );
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    issue_hs  = 1'b0;
    take_resp = 1'b0;
    expire    = 1'b0;
    issue_c   = '0;
    case (state)
      ST_IDLE: begin
        if (|pend) begin
          idx_nxt   = rr_pick(pend, rr_ptr);
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.asa_req_rdy) begin
          issue_hs     = 1'b1;
          issue_c[idx] = 1'b1;
          state_nxt    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.asa_resp_val) begin
          take_resp = 1'b1;
          state_nxt = ST_RESP;
        end else if ((TIMEOUT != 0) && (wd_cnt == WD_LAST)) begin
          expire    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (bus.out_rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, round-robin pointer, watchdog and current header.
  always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
    if (!clk_ctrl_rst_low) begin
      state   <= ST_IDLE;
      idx     <= '0;
      rr_ptr  <= IDX_W'(N_REQ - 1);
      wd_cnt  <= '0;
      cur_hdr <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (issue_hs) begin
        rr_ptr  <= idx;
        cur_hdr <= slot_hdr[idx];
        wd_cnt  <= '0;
      end else if ((state == ST_WAIT) && !bus.asa_resp_val && (wd_cnt != '1)) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
    end
  end

  // Registered outputs; valids/readies follow the next state so they
  // depend on registered state only.
  always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
    if (!clk_ctrl_rst_low) begin
      asa_req_val_q  <= 1'b0;
      asa_req_msg_q  <= '0;
      asa_resp_rdy_q <= 1'b0;
      out_val_q      <= 1'b0;
      out_hdr_q      <= '0;
      out_data_q     <= '0;
      out_src_q      <= '0;
      timeout_err_q  <= 1'b0;
      err_sticky_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      asa_req_val_q  <= (state_nxt == ST_ISSUE);
      asa_resp_rdy_q <= (state_nxt == ST_WAIT);
      out_val_q      <= (state_nxt == ST_RESP);
      busy_q         <= (state_nxt != ST_IDLE);
      timeout_err_q  <= expire;
      err_sticky_q   <= err_sticky_q | expire | (|drop);
      if ((state == ST_IDLE) && (|pend)) asa_req_msg_q <= slot_msg[idx_nxt];
      if (take_resp) begin
        out_data_q <= bus.asa_resp_data;
        out_hdr_q  <= cur_hdr;
        out_src_q  <= idx;
      end
    end
  end

  assign bus.req_rdy      = rdy;
  assign bus.req_ovf      = ovf;
  assign bus.asa_req_val  = asa_req_val_q;
  assign bus.asa_req_msg  = asa_req_msg_q;
  assign bus.asa_resp_rdy = asa_resp_rdy_q;
  assign bus.out_val      = out_val_q;
  assign bus.out_hdr      = out_hdr_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_src      = out_src_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.err_sticky   = err_sticky_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_asa_req_sched.sv
// Directed bench for asa_req_sched: single request, contention, overflow,
// accept-on-free, watchdog expiry and asynchronous reset mid-operation.
module tb_asa_req_sched;
  import asa_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  asa_req_sched_if #(.N_REQ(2), .IDX_W(1)) bus ();

  asa_req_sched #(.N_REQ(2), .IDX_W(1), .TIMEOUT(8)) dut (
    .clk_ctrl         (clk),
    .clk_ctrl_rst_low (rst_n),
    .bus              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ASAReqMsg mk(input asa_inst_e inst, input logic [31:0] key,
                                  input logic [63:0] data);
    ASAReqMsg m;
    m.inst = inst;
    m.key  = key;
    m.data = data;
    return m;
  endfunction

  task automatic set_hdr(input int p, input logic [31:0] h);
    bus.hdr_vld[p] = 1'b1;
    bus.hdr[p]     = h;
    step();
    bus.hdr_vld = '0;
  endtask

  task automatic put(input int p, input logic [31:0] key, input logic [63:0] data);
    bus.req_val[p] = 1'b1;
    bus.req_msg[p] = mk(ASA_PUT, key, data);
    step();
    bus.req_val = '0;
  endtask

  // Issue, respond immediately and drain one response; checks source port.
  task automatic serve(input int src, input logic [31:0] key, input logic [31:0] hdr,
                       input logic [63:0] rdata);
    int n = 0;
    while (bus.asa_req_val !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk("serve_issue_val", 128'(bus.asa_req_val), 128'(1));
    chk("serve_issue_key", 128'(bus.asa_req_msg.key), 128'(key));
    bus.asa_req_rdy = 1'b1;
    step();
    chk("serve_resp_rdy", 128'(bus.asa_resp_rdy), 128'(1));
    bus.asa_resp_val  = 1'b1;
    bus.asa_resp_data = rdata;
    step();
    bus.asa_resp_val = 1'b0;
    chk("serve_out_val", 128'(bus.out_val), 128'(1));
    chk("serve_out_src", 128'(bus.out_src), 128'(src));
    chk("serve_out_hdr", 128'(bus.out_hdr), 128'(hdr));
    chk("serve_out_data", 128'(bus.out_data), 128'(rdata));
    bus.out_rdy = 1'b1;
    step();
    bus.out_rdy = 1'b0;
    chk("serve_out_drop", 128'(bus.out_val), 128'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_rdy"}, 128'(bus.req_rdy), 128'(2'b11));
    chk({tag, "_req_ovf"}, 128'(bus.req_ovf), 128'(0));
    chk({tag, "_asa_req_val"}, 128'(bus.asa_req_val), 128'(0));
    chk({tag, "_asa_req_msg"}, 128'(bus.asa_req_msg), 128'(0));
    chk({tag, "_asa_resp_rdy"}, 128'(bus.asa_resp_rdy), 128'(0));
    chk({tag, "_out_val"}, 128'(bus.out_val), 128'(0));
    chk({tag, "_out_hdr"}, 128'(bus.out_hdr), 128'(0));
    chk({tag, "_out_data"}, 128'(bus.out_data), 128'(0));
    chk({tag, "_out_src"}, 128'(bus.out_src), 128'(0));
    chk({tag, "_timeout_err"}, 128'(bus.timeout_err), 128'(0));
    chk({tag, "_err_sticky"}, 128'(bus.err_sticky), 128'(0));
    chk({tag, "_busy"}, 128'(bus.busy), 128'(0));
  endtask

  initial begin
    int n;
    rst_n             = 1'b0;
    bus.hdr_vld       = '0;
    bus.hdr           = '0;
    bus.req_val       = '0;
    bus.req_msg       = '0;
    bus.asa_req_rdy   = 1'b1;
    bus.asa_resp_val  = 1'b0;
    bus.asa_resp_data = '0;
    bus.out_rdy       = 1'b0;
    step();
    step();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    step();

    // Single request on port 0.
    set_hdr(0, 32'h1234_0000);
    bus.req_val[0] = 1'b1;
    bus.req_msg[0] = mk(ASA_PUT, 32'd5, 64'hA);
    step();
    bus.req_val = '0;
    chk("single_rdy_t1", 128'(bus.req_rdy[0]), 128'(0));
    chk("single_val_t1", 128'(bus.asa_req_val), 128'(0));
    step();
    chk("single_val_t2", 128'(bus.asa_req_val), 128'(1));
    chk("single_inst", 128'(bus.asa_req_msg.inst), 128'(ASA_PUT));
    chk("single_key", 128'(bus.asa_req_msg.key), 128'(5));
    chk("single_data", 128'(bus.asa_req_msg.data), 128'(64'hA));
    step();
    chk("single_val_done", 128'(bus.asa_req_val), 128'(0));
    chk("single_resp_rdy", 128'(bus.asa_resp_rdy), 128'(1));
    chk("single_slot_free", 128'(bus.req_rdy), 128'(2'b11));
    step();
    step();
    bus.asa_resp_val  = 1'b1;
    bus.asa_resp_data = 64'hBEEF;
    step();
    bus.asa_resp_val = 1'b0;
    chk("single_out_val", 128'(bus.out_val), 128'(1));
    chk("single_out_hdr", 128'(bus.out_hdr), 128'(32'h1234_0000));
    chk("single_out_data", 128'(bus.out_data), 128'(64'hBEEF));
    chk("single_out_src", 128'(bus.out_src), 128'(0));
    step();
    chk("single_out_hold", 128'(bus.out_val), 128'(1));
    chk("single_data_hold", 128'(bus.out_data), 128'(64'hBEEF));
    bus.out_rdy = 1'b1;
    step();
    bus.out_rdy = 1'b0;
    chk("single_out_done", 128'(bus.out_val), 128'(0));
    chk("single_idle", 128'(bus.busy), 128'(0));

    // Contention: both ports strobe together, grants alternate from port 0.
    do_reset();
    set_hdr(0, 32'hA000_0000);
    set_hdr(1, 32'hB000_0000);
    for (int r = 0; r < 4; r++) begin
      bus.req_val    = 2'b11;
      bus.req_msg[0] = mk(ASA_GET, 32'h100 + 32'(r), 64'(r));
      bus.req_msg[1] = mk(ASA_GET, 32'h200 + 32'(r), 64'(r));
      step();
      bus.req_val = '0;
      serve(0, 32'h100 + 32'(r), 32'hA000_0000, 64'h1000 + 64'(r));
      serve(1, 32'h200 + 32'(r), 32'hB000_0000, 64'h2000 + 64'(r));
    end
    chk("cont_no_ovf", 128'(bus.err_sticky), 128'(0));

    // Overflow: core stalls, port 1 strobes twice.
    bus.asa_req_rdy = 1'b0;
    put(1, 32'h31, 64'h3131);
    bus.req_val[1] = 1'b1;
    bus.req_msg[1] = mk(ASA_PUT, 32'h32, 64'h3232);
    step();
    bus.req_val = '0;
    chk("ovf_pulse", 128'(bus.req_ovf), 128'(2'b10));
    chk("ovf_sticky", 128'(bus.err_sticky), 128'(1));
    chk("ovf_issue_val", 128'(bus.asa_req_val), 128'(1));
    step();
    chk("ovf_pulse_end", 128'(bus.req_ovf), 128'(0));
    chk("ovf_key_kept", 128'(bus.asa_req_msg.key), 128'(32'h31));
    chk("ovf_data_kept", 128'(bus.asa_req_msg.data), 128'(64'h3131));
    serve(1, 32'h31, 32'hB000_0000, 64'h3300);

    // Accept on free: new request coincides with port 0's issue handshake.
    bus.asa_req_rdy = 1'b0;
    put(0, 32'h41, 64'h4141);
    step();
    chk("aof_issue_key", 128'(bus.asa_req_msg.key), 128'(32'h41));
    bus.asa_req_rdy = 1'b1;
    bus.req_val[0]  = 1'b1;
    bus.req_msg[0]  = mk(ASA_PUT, 32'h42, 64'h4242);
    step();
    bus.req_val = '0;
    chk("aof_accepted", 128'(bus.req_rdy[0]), 128'(0));
    chk("aof_no_ovf", 128'(bus.req_ovf), 128'(0));
    bus.asa_resp_val  = 1'b1;
    bus.asa_resp_data = 64'h4400;
    step();
    bus.asa_resp_val = 1'b0;
    chk("aof_first_src", 128'(bus.out_src), 128'(0));
    bus.out_rdy = 1'b1;
    step();
    bus.out_rdy = 1'b0;
    serve(0, 32'h42, 32'hA000_0000, 64'h4500);

    // Watchdog: no response, expiry after 8 WAIT cycles.
    do_reset();
    bus.asa_req_rdy = 1'b1;
    put(1, 32'h51, 64'h5151);
    step();
    chk("wd_issue", 128'(bus.asa_req_val), 128'(1));
    step();
    chk("wd_wait", 128'(bus.asa_resp_rdy), 128'(1));
    for (int i = 0; i < 7; i++) begin
      step();
      chk("wd_no_early_err", 128'(bus.timeout_err), 128'(0));
      chk("wd_still_busy", 128'(bus.busy), 128'(1));
    end
    step();
    chk("wd_err_pulse", 128'(bus.timeout_err), 128'(1));
    chk("wd_idle", 128'(bus.busy), 128'(0));
    chk("wd_resp_rdy_off", 128'(bus.asa_resp_rdy), 128'(0));
    chk("wd_no_out", 128'(bus.out_val), 128'(0));
    chk("wd_sticky", 128'(bus.err_sticky), 128'(1));
    step();
    chk("wd_err_end", 128'(bus.timeout_err), 128'(0));
    chk("wd_no_out_after", 128'(bus.out_val), 128'(0));

    // Reset while waiting for the core.
    do_reset();
    put(0, 32'h61, 64'h6161);
    n = 0;
    while (bus.asa_resp_rdy !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("rstw_in_wait", 128'(bus.asa_resp_rdy), 128'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rstw");
    step();
    rst_n = 1'b1;
    step();

    // Reset while a response is held with out_rdy low.
    set_hdr(1, 32'hCAFE_0000);
    put(1, 32'h71, 64'h7171);
    n = 0;
    while (bus.asa_req_val !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    step();
    bus.asa_resp_val  = 1'b1;
    bus.asa_resp_data = 64'h7777;
    step();
    bus.asa_resp_val = 1'b0;
    chk("rstr_out_val", 128'(bus.out_val), 128'(1));
    chk("rstr_out_hdr", 128'(bus.out_hdr), 128'(32'hCAFE_0000));
    chk("rstr_out_src", 128'(bus.out_src), 128'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rstr");
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
